// File: rtl/line_clear_ctrl_if.sv
// Board handshake between the game logic (master) and the line-clear sequencer (slave).
interface line_clear_ctrl_if #(
    parameter int ROWS = 20,
    parameter int COLS = 20
);
    localparam int CNT_W = $clog2(ROWS + 1);

    logic                        start;
    logic [0:ROWS-1][COLS-1:0]   board_in;
    logic [0:ROWS-1][COLS-1:0]   board_out;
    logic                        board_wr;
    logic                        busy;
    logic                        done;
    logic [CNT_W-1:0]            lines_cleared;
    logic [15:0]                 score;
    logic                        game_over;

    modport master (
        output start, board_in,
        input  board_out, board_wr, busy, done, lines_cleared, score, game_over
    );

    modport slave (
        input  start, board_in,
        output board_out, board_wr, busy, done, lines_cleared, score, game_over
    );
endinterface

// File: rtl/line_clear_ctrl.sv
// Snapshots the playfield, removes full rows bottom-up while dropping the rows above,
// then strobes the compacted board back and updates score and game-over.
module line_clear_ctrl #(
    parameter int ROWS            = 20,
    parameter int COLS            = 20,
    parameter int POINTS_PER_LINE = 3
) (
    input  logic              frame_clk,
    input  logic              Reset,
    line_clear_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t                    state, state_nxt;
    logic [0:ROWS-1][COLS-1:0] work;
    logic [PTR_W-1:0]          row_ptr;
    logic [PTR_W-1:0]          shift_ptr;
    logic [CNT_W-1:0]          line_cnt;
    logic [CNT_W-1:0]          lines_q;
    logic [15:0]               score_q;
    logic                      game_over_q;

    logic                      row_full;
    logic                      accept;
    logic [15:0]               points;
    logic [16:0]               sum;
    logic [15:0]               score_sat;

    assign row_full  = &work[row_ptr];
    assign accept    = bus.start && !game_over_q;
    assign points    = 16'(line_cnt) * 16'(POINTS_PER_LINE);
    assign sum       = {1'b0, score_q} + {1'b0, points};
    assign score_sat = sum[16] ? 16'hFFFF : sum[15:0];

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (row_full) state_nxt = SHIFT;
                     else if (row_ptr == '0) state_nxt = DONE;
            SHIFT:   if (shift_ptr == '0) state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the working board is a plain register array, so it is cleared by reset like
    // any other state; the write-back port must read zero straight out of reset.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            work        <= '0;
            row_ptr     <= '0;
            shift_ptr   <= '0;
            line_cnt    <= '0;
            lines_q     <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees the
            // value from before this edge, e.g. the row copy below reads the old neighbour.
            case (state)
                IDLE: begin
                    if (accept) begin
                        work     <= bus.board_in;
                        row_ptr  <= LAST_ROW;
                        line_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        shift_ptr <= row_ptr;
                    end else if (row_ptr == '0) begin
                        lines_q <= line_cnt;
                        score_q <= score_sat;
                    end else begin
                        row_ptr <= row_ptr - PTR_ONE;
                    end
                end
                SHIFT: begin
                    if (shift_ptr != '0) begin
                        work[shift_ptr] <= work[shift_ptr - PTR_ONE];
                        shift_ptr       <= shift_ptr - PTR_ONE;
                    end else begin
                        // Row pointer stays put so the row that dropped in is re-checked.
                        work[0]  <= '0;
                        line_cnt <= line_cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    game_over_q <= game_over_q | (|work[0]);
                end
                default: ;
            endcase
        end
    end

    assign bus.board_out     = work;
    assign bus.board_wr      = (state == DONE);
    assign bus.done          = (state == DONE);
    assign bus.busy          = (state != IDLE);
    assign bus.lines_cleared = lines_q;
    assign bus.score         = score_q;
    assign bus.game_over     = game_over_q;
endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: a behavioural model predicts each operation's
// compacted board, counts, score and completion cycle; the monitor compares on done.
module tb_line_clear_ctrl;
    localparam int ROWS = 20;
    localparam int COLS = 20;
    localparam int PPL  = 3;
    localparam int BW   = ROWS * COLS;

    typedef logic [0:ROWS-1][COLS-1:0] board_t;

    typedef struct {
        board_t      board;
        logic [4:0]  lines;
        logic [15:0] score;
        int          done_cyc;
    } exp_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [15:0] m_score = '0;
    logic        m_go    = 1'b0;

    line_clear_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .POINTS_PER_LINE(PPL)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural prediction: keep non-full rows in order, packed to the bottom.
    function automatic exp_t model(input board_t b, input logic [15:0] sc, input int k);
        exp_t e;
        int   c   = 0;
        int   lat = ROWS;
        int   w   = ROWS - 1;
        int   s;
        e.board = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (&b[i]) begin
                lat += (i + c) + 2;
                c++;
            end else begin
                e.board[w] = b[i];
                w--;
            end
        end
        s = int'(sc) + c * PPL;
        e.score    = (s > 65535) ? 16'hFFFF : 16'(s);
        e.lines    = 5'(c);
        e.done_cyc = k + lat;
        return e;
    endfunction

    always @(negedge frame_clk) begin
        if (Reset && (bus.done || bus.board_wr)) begin
            check("wr_eq_done", BW'(bus.board_wr), BW'(bus.done));
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("extra_done", BW'(1), BW'(0));
            end else begin
                cur = sb_q.pop_front();
                check("done_cycle", BW'(cyc), BW'(cur.done_cyc));
                check("board_out", BW'(bus.board_out), BW'(cur.board));
                check("lines", BW'(bus.lines_cleared), BW'(cur.lines));
                check("score", BW'(bus.score), BW'(cur.score));
            end
        end
    end

    task automatic do_start(input board_t b);
        exp_t e;
        logic acc;
        @(negedge frame_clk);
        acc          = !m_go;
        bus.start    = 1'b1;
        bus.board_in = b;
        if (acc) begin
            e = model(b, m_score, cyc + 1);
            sb_q.push_back(e);
            m_score = e.score;
            m_go    = |e.board[0];
        end
        @(negedge frame_clk);
        bus.start    = 1'b0;
        bus.board_in = '0;
        check("busy_after_start", BW'(bus.busy), BW'(acc));
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge frame_clk);
            if (sb_q.size() == 0 && !bus.busy) ok = 1'b1;
        end
        if (!ok) check("timeout", BW'(0), BW'(1));
    endtask

    task automatic apply_reset();
        #2 Reset = 1'b0;
        #1;
        check("rst_busy", BW'(bus.busy), BW'(0));
        check("rst_done", BW'(bus.done), BW'(0));
        check("rst_wr", BW'(bus.board_wr), BW'(0));
        check("rst_board", BW'(bus.board_out), BW'(0));
        check("rst_lines", BW'(bus.lines_cleared), BW'(0));
        check("rst_score", BW'(bus.score), BW'(0));
        check("rst_game_over", BW'(bus.game_over), BW'(0));
        sb_q.delete();
        m_score = '0;
        m_go    = 1'b0;
        @(negedge frame_clk);
        Reset = 1'b1;
    endtask

    initial begin
        board_t b;
        int     d0;
        bus.start    = 1'b0;
        bus.board_in = '0;
        apply_reset();

        // Empty board: pure scan latency, nothing changes.
        do_start('0);
        wait_done();

        // One full row at the bottom with a partial row above it.
        b = '0; b[19] = 20'hFFFFF; b[18] = 20'h00001;
        do_start(b);
        wait_done();

        // Four stacked full rows under a lone cell.
        apply_reset();
        b = '0; for (int r = 16; r < 20; r++) b[r] = 20'hFFFFF;
        b[15] = 20'h80000;
        do_start(b);
        wait_done();

        // Interleaved full rows, issued twice so the score accumulates.
        apply_reset();
        b = '0; b[19] = 20'hFFFFF; b[17] = 20'hFFFFF; b[18] = 20'h00F00; b[16] = 20'h0000F;
        do_start(b);
        wait_done();
        do_start(b);
        wait_done();
        check("score_twice", BW'(bus.score), BW'(16'd12));

        // start pulsed mid-SHIFT must be ignored.
        apply_reset();
        d0 = done_cnt;
        b = '0; b[19] = 20'hFFFFF; b[18] = 20'h00001;
        do_start(b);
        repeat (3) @(negedge frame_clk);
        check("busy_mid_shift", BW'(bus.busy), BW'(1));
        bus.start = 1'b1; bus.board_in = '1;
        @(negedge frame_clk);
        bus.start = 1'b0; bus.board_in = '0;
        wait_done();
        repeat (30) @(negedge frame_clk);
        check("one_done", BW'(done_cnt), BW'(d0 + 1));

        // Reset mid-SHIFT aborts without a write strobe.
        d0 = done_cnt;
        do_start(b);
        repeat (4) @(negedge frame_clk);
        apply_reset();
        repeat (60) @(negedge frame_clk);
        check("abort_no_done", BW'(done_cnt), BW'(d0));
        check("abort_idle", BW'(bus.busy), BW'(0));

        // Cell in row 0 sets game_over; later starts are ignored until reset.
        b = '0; b[0] = 20'h00010; b[10] = 20'h12345;
        do_start(b);
        wait_done();
        check("game_over_set", BW'(bus.game_over), BW'(1));
        d0 = done_cnt;
        do_start('0);
        repeat (30) @(negedge frame_clk);
        check("go_no_done", BW'(done_cnt), BW'(d0));
        check("go_still_idle", BW'(bus.busy), BW'(0));
        apply_reset();

        // Completely full board: everything clears, game_over stays low.
        b = '1;
        do_start(b);
        wait_done();
        check("full_game_over", BW'(bus.game_over), BW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
- Sequencer for the 20x20 playfield occupancy board.
- When the game logic locks a piece, it pulses start with the current board. The block then:
  - snapshots the board,
  - walks it bottom-up, removing each full row and shifting every row above it down one row per cycle,
  - writes the compacted board back with a one-cycle strobe,
  - updates a running score and a sticky game-over flag.

Parameters:
- ROWS, 20, number of board rows; row 0 is the top.
- COLS, 20, number of board columns; bit c of a row word is column c.
- POINTS_PER_LINE, 3, score added per cleared row.

Ports:
- frame_clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to process board_in; sampled only in IDLE.
- board_in  input  [0:ROWS-1][COLS-1:0]  board snapshot; valid in the cycle start is high.
- board_out  output  [0:ROWS-1][COLS-1:0]  working/compacted board; driven directly from the internal register.
- board_wr  output  1  one-cycle strobe; board_out is final and must be written back.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse, coincident with board_wr.
- lines_cleared  output  5  rows removed by the last operation; holds until the next start.
- score  output  16  accumulated score; saturates at 16'hFFFF.
- game_over  output  1  sticky; set when the final board has any cell in row 0.

Behaviour:
- Reset (asynchronous, Reset=0), all of the following take effect immediately:
  - State goes to IDLE.
  - board_out, score, lines_cleared = 0.
  - board_wr, done, busy, game_over = 0.
  - Internal row_ptr, shift_ptr and line counter = 0.
  - Reset asserted mid-operation aborts with no write strobe.
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - If start=1 and game_over=0: work <= board_in, row_ptr <= ROWS-1, line counter <= 0, go to SCAN.
  - If start=1 and game_over=1: start is ignored.
- SCAN, one row checked per cycle:
  - If work[row_ptr] is all ones: shift_ptr <= row_ptr, go to SHIFT.
  - Else if row_ptr==0: go to DONE. On this transition, lines_cleared <= counter and score <= sat16(score + counter*POINTS_PER_LINE).
  - Else: row_ptr <= row_ptr-1.
- SHIFT, one row moved per cycle:
  - If shift_ptr>0: work[shift_ptr] <= work[shift_ptr-1], shift_ptr <= shift_ptr-1.
  - If shift_ptr==0: work[0] <= 0, counter <= counter+1, return to SCAN with row_ptr unchanged, so the row that just dropped in is re-checked.
- DONE, lasts one cycle:
  - board_wr=1 and done=1 (Moore outputs).
  - game_over <= game_over | (|work[0]).
  - Go to IDLE.
- start asserted while busy=1: ignored, not queued.
- Arithmetic:
  - counter*POINTS_PER_LINE is computed at 16 bits.
  - Sum is computed at 17 bits and clamped to 16'hFFFF.
  - Counter maximum is ROWS (20), which fits 5 bits.
- Latency, start sampled at edge k:
  - No full rows: SCAN occupies 20 cycles, DONE occupies the cycle starting at edge k+20, done high during [k+20, k+21).
  - Each full row at index r adds r+1 SHIFT cycles, plus one SCAN cycle for the re-check.
- Full board (all 20 rows full): 20 clears, lines_cleared=20, board_out all zero, game_over stays 0.
- board_out changes during SCAN/SHIFT; consumers latch it only on board_wr.

Test Plan:
- Empty board, start at edge k -> busy high, done/board_wr high for exactly one cycle at k+20, lines_cleared=0, score=0, board_out all zero.
- Row19=20'hFFFFF, row18=20'h00001, rest 0 -> done at k+41, board_out row19=20'h00001, all other rows 0, lines_cleared=1, score=3.
- Rows 16..19 full, row15=20'h80000 -> lines_cleared=4, score=12, board_out row19=20'h80000, rows 0..18 = 0.
- Rows 19 and 17 full, row18=20'h00F00, row16=20'h0000F -> lines_cleared=2, row19=20'h00F00, row18=20'h0000F, others 0; a second identical start -> score=12.
- start pulsed again mid-SHIFT -> ignored, exactly one done pulse. Reset low mid-SHIFT -> all outputs 0 immediately, state IDLE, no board_wr.
- Board with row0=20'h00010, no full rows -> game_over=1 after DONE. Following start -> busy stays 0, no done. Reset clears game_over.
